// File: rtl/preg_free_list_if.sv
// Free-list handshake bundle: allocation (rename) and release (retire).
// slave: free list side; master: rename/retire side.
interface preg_free_list_if #(
  parameter int PREG_W = 5
);
  logic              alloc_valid_o;
  logic [PREG_W-1:0] alloc_preg_o;
  logic              alloc_ready_i;
  logic              free_valid_i;
  logic [PREG_W-1:0] free_preg_i;

  modport slave (
    output alloc_valid_o,
    output alloc_preg_o,
    input  alloc_ready_i,
    input  free_valid_i,
    input  free_preg_i
  );

  modport master (
    input  alloc_valid_o,
    input  alloc_preg_o,
    output alloc_ready_i,
    output free_valid_i,
    output free_preg_i
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical-register free list: circular FIFO of free preg IDs, rebuilt by
// an INIT walk after rst/squash. Ports: clk, rst (sync, active-high),
// squash_i, fl (slave: alloc_valid_o/alloc_preg_o/alloc_ready_i,
// free_valid_i/free_preg_i), count_o, init_done_o, err_o.
// Optional macro PREG_FREE_LIST_CHECK_EN adds double-free/overflow checks.
module preg_free_list #(
  parameter int NPREG  = 32,
  parameter int PREG_W = $clog2(NPREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              squash_i,
  preg_free_list_if.slave   fl,
  output logic [PREG_W:0]   count_o,
  output logic              init_done_o,
  output logic              err_o
);

  localparam logic [PREG_W:0] FULL = (PREG_W+1)'(NPREG);
  localparam logic [PREG_W:0] LAST = FULL - (PREG_W+1)'(1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t            state_q;
  logic [PREG_W:0]   walk_q;
  logic [PREG_W-1:0] head_q;
  logic [PREG_W-1:0] tail_q;
  logic [PREG_W:0]   count_q;
  logic              done_q;
  logic              err_q;
  logic [PREG_W-1:0] mem_q [NPREG];

  logic              run;
  logic              full;
  logic              alloc_valid;
  logic              alloc_fire;
  logic              free_fire;
  logic              init_wr;
  logic              err_set;
  logic [PREG_W:0]   count_d;

`ifdef PREG_FREE_LIST_CHECK_EN
  logic [NPREG-1:0]  inlist_q;
  logic              dup;
`endif

  always_comb begin
    run         = (state_q == S_RUN);
    full        = (count_q == FULL);
    alloc_valid = run && (count_q != '0);
    alloc_fire  = alloc_valid && fl.alloc_ready_i && !squash_i;
    init_wr     = !run && !squash_i && !rst;
`ifdef PREG_FREE_LIST_CHECK_EN
    dup         = inlist_q[fl.free_preg_i];
    free_fire   = run && !squash_i && fl.free_valid_i && !full && !dup;
    // a free in INIT is flagged even when a squash lands the same cycle
    err_set     = fl.free_valid_i &&
                  (!run || (!squash_i && (full || dup)));
`else
    free_fire   = run && !squash_i && fl.free_valid_i && !full;
    err_set     = 1'b0;
`endif
    count_d     = count_q
                + (PREG_W+1)'(free_fire)
                - (PREG_W+1)'(alloc_fire);
  end

  // gated so the presented ID is 0 while nothing is offered
  always_comb begin
    fl.alloc_valid_o = alloc_valid;
    fl.alloc_preg_o  = alloc_valid ? mem_q[head_q] : '0;
    count_o          = count_q;
    init_done_o      = done_q;
    err_o            = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      walk_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      if (squash_i) begin
        state_q <= S_INIT;
        walk_q  <= '0;
        count_q <= '0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_INIT: begin
            walk_q <= walk_q + (PREG_W+1)'(1);
            if (walk_q == LAST) begin
              state_q <= S_RUN;
              walk_q  <= '0;
              head_q  <= '0;
              tail_q  <= '0;
              count_q <= FULL;
              done_q  <= 1'b1;
            end
          end
          S_RUN: begin
            if (alloc_fire)
              head_q <= head_q + PREG_W'(1);
            if (free_fire)
              tail_q <= tail_q + PREG_W'(1);
            count_q <= count_d;
          end
          default: begin
            state_q <= S_INIT;
            walk_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_wr)
      mem_q[walk_q[PREG_W-1:0]] <= walk_q[PREG_W-1:0];
    else if (free_fire)
      mem_q[tail_q] <= fl.free_preg_i;
  end

`ifdef PREG_FREE_LIST_CHECK_EN
  // free_fire excludes pregs already listed, so clear/set never collide
  always_ff @(posedge clk) begin
    if (rst || squash_i) begin
      inlist_q <= '0;
    end else begin
      if (init_wr)
        inlist_q[walk_q[PREG_W-1:0]] <= 1'b1;
      if (alloc_fire)
        inlist_q[mem_q[head_q]] <= 1'b0;
      if (free_fire)
        inlist_q[fl.free_preg_i] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_preg_free_list.sv
// Testbench for preg_free_list (NPREG=8): directed vector table,
// hand-written squash sequences, randomized run against a queue model.
module tb_preg_free_list;

  localparam int NPREG  = 8;
  localparam int PREG_W = 3;
`ifdef PREG_FREE_LIST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            squash;
  logic [PREG_W:0] count;
  logic            done;
  logic            err;

  preg_free_list_if #(.PREG_W(PREG_W)) fl ();

  preg_free_list #(
    .NPREG (NPREG),
    .PREG_W(PREG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .squash_i   (squash),
    .fl         (fl),
    .count_o    (count),
    .init_done_o(done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit r;
    bit s;
    bit rdy;
    bit fv;
    int fp;
    bit ev;
    int ep;
    int ec;
    bit ed;
    bit ee;
  } vec_t;

  vec_t tv[$];

  // reference model: queue of free IDs plus an init countdown
  bit m_init;
  int m_walk;
  int m_q[$];
  bit m_err;

  function automatic bit in_q(int p);
    foreach (m_q[i]) if (m_q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(bit r, bit s, bit rdy, bit fv, int fp);
    bit al;
    bit acc;
    if (r) begin
      m_init = 1; m_walk = 0; m_q.delete(); m_err = 0;
    end else if (s) begin
      if (CHK && m_init && fv) m_err = 1;
      m_init = 1; m_walk = 0; m_q.delete();
    end else if (m_init) begin
      if (CHK && fv) m_err = 1;
      m_walk++;
      if (m_walk == NPREG) begin
        m_init = 0;
        for (int k = 0; k < NPREG; k++) m_q.push_back(k);
      end
    end else begin
      al  = (m_q.size() != 0) && rdy;
      acc = fv;
      if (fv && m_q.size() == NPREG) begin
        acc = 0;
        if (CHK) m_err = 1;
      end
      if (CHK && fv && in_q(fp)) begin
        acc = 0;
        m_err = 1;
      end
      if (al) void'(m_q.pop_front());
      if (acc) m_q.push_back(fp);
    end
  endtask

  task automatic cmp(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  task automatic step(bit r, bit s, bit rdy, bit fv, int fp);
    rst              = r;
    squash           = s;
    fl.alloc_ready_i = rdy;
    fl.free_valid_i  = fv;
    fl.free_preg_i   = PREG_W'(fp);
    @(posedge clk);
    model_step(r, s, rdy, fv, fp);
    #1;
  endtask

  task automatic chk(string tag, bit ev, int ep, int ec, bit ed, bit ee);
    cmp({tag, ".valid"}, int'(fl.alloc_valid_o), int'(ev));
    cmp({tag, ".preg"},  int'(fl.alloc_preg_o),  ep);
    cmp({tag, ".count"}, int'(count),            ec);
    cmp({tag, ".done"},  int'(done),             int'(ed));
    cmp({tag, ".err"},   int'(err),              int'(ee));
  endtask

  task automatic chk_model(string tag);
    bit v;
    v = !m_init && (m_q.size() != 0);
    chk(tag, v, v ? m_q[0] : 0, m_init ? 0 : m_q.size(), !m_init, m_err);
  endtask

  function automatic void add(bit r, bit s, bit rdy, bit fv, int fp,
                              bit ev, int ep, int ec, bit ed, bit ee);
    vec_t v;
    v.r = r; v.s = s; v.rdy = rdy; v.fv = fv; v.fp = fp;
    v.ev = ev; v.ep = ep; v.ec = ec; v.ed = ed; v.ee = ee;
    tv.push_back(v);
  endfunction

  function automatic void add_init();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < NPREG - 1; k++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, NPREG, 1, 0);
  endfunction

  initial begin
    int wl[8];
    wl = '{6, 7, 0, 1, 2, 3, 4, 5};
    rst = 1; squash = 0;
    fl.alloc_ready_i = 0; fl.free_valid_i = 0; fl.free_preg_i = '0;

    // reset, init walk, drain, extra ready
    add_init();
    for (int k = 1; k <= NPREG; k++)
      add(0, 0, 1, 0, 0, k < NPREG, k < NPREG ? k : 0, NPREG - k, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    // refill from empty, alloc+free together, drain
    add(0, 0, 0, 1, 5, 1, 5, 1, 1, 0);
    add(0, 0, 1, 1, 3, 1, 3, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    // wrap-around from a fresh list
    add_init();
    for (int k = 1; k <= 6; k++)
      add(0, 0, 1, 0, 0, 1, k, NPREG - k, 1, 0);
    for (int j = 0; j < 6; j++)
      add(0, 0, 0, 1, j, 1, 6, 3 + j, 1, 0);
    // free while full is dropped
    add(0, 0, 0, 1, 2, 1, 6, NPREG, 1, CHK);
    for (int k = 1; k <= NPREG; k++)
      add(0, 0, 1, 0, 0, k < NPREG, k < NPREG ? wl[k] : 0,
          NPREG - k, 1, CHK);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].s, tv[i].rdy, tv[i].fv, tv[i].fp);
      chk($sformatf("vec%0d", i), tv[i].ev, tv[i].ep, tv[i].ec,
          tv[i].ed, tv[i].ee);
    end

    // squash mid-run with count=3 and alloc+free in the same cycle
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < NPREG; k++) step(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);
    chk("sq.pre", 1, 5, 3, 1, 0);
    step(0, 1, 1, 1, 0);
    chk("sq.hit", 0, 0, 0, 0, 0);
    for (int k = 0; k < NPREG - 1; k++) step(0, 0, 0, 0, 0);
    chk("sq.walk", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sq.done", 1, 0, NPREG, 1, 0);

    // squash during INIT restarts the walk
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < NPREG - 1; k++) step(0, 0, 0, 0, 0);
    chk("sqi.walk", 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("sqi.done", 1, 0, NPREG, 1, 0);

    // randomized run against the model
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0,
           int'($urandom_range(0, NPREG - 1)));
      chk_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
